// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of RUN cycles needed to cover the full operand width.
  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; a single-chunk configuration still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB
// so the top level can derive signed overflow on the final chunk.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c_s;

  // Bit-serial ripple of the carry through the chunk.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c_s[CHUNK];
  assign cm = c_s[CHUNK-1];

endmodule

// File: rtl/seq_addsub_chk.sv
// Protocol properties for seq_addsub: busy/done exclusivity, one-cycle done,
// and busy tracking the RUN state.
module seq_addsub_chk
  import addsub_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  input logic   busy,
  input logic   done,
  input state_t state
);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  a_done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_busy_is_run: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state == ST_RUN));

  a_done_is_done: assert property (@(posedge clk) disable iff (!rst_n)
    done == (state == ST_DONE));

endmodule

// File: rtl/seq_addsub.sv
// Sequential adder/subtractor: processes CHUNK bits per cycle, LSB chunk first,
// and publishes sum/cout/ovf into held result registers with a one-cycle done.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                NCH      = nch(WIDTH, CHUNK);
  localparam int                IDXW     = idx_width(NCH);
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NCH - 1);
  localparam logic [WIDTH-1:0]  CH_MASK  = WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 4) begin : g_bad_width
    $error("seq_addsub: WIDTH must be at least 4");
  end
  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_addsub: CHUNK must be at least 1");
  end
  if ((WIDTH % CHUNK) != 0) begin : g_bad_ratio
    $error("seq_addsub: WIDTH must be an integer multiple of CHUNK");
  end

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] acc_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic [31:0]      base_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK-1:0] s_s;
  logic             co_s;
  logic             cm_s;
  logic [WIDTH-1:0] acc_next_s;

  // Select the current chunk of the latched operands and merge its sum into
  // the partial accumulator; shifts avoid out-of-range part selects.
  always_comb begin
    base_s     = 32'(idx_r) * 32'(CHUNK);
    a_chunk_s  = CHUNK'(a_r >> base_s);
    b_chunk_s  = CHUNK'(b_r >> base_s);
    acc_next_s = (acc_r & ~(CH_MASK << base_s)) | (WIDTH'(s_s) << base_s);
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a  (a_chunk_s),
    .b  (b_chunk_s),
    .ci (carry_r),
    .s  (s_s),
    .co (co_s),
    .cm (cm_s)
  );

  // Control FSM, operand latch, chunk sequencing and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      acc_r   <= '0;
      idx_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + ~borrow; cout then reads as "no borrow".
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub ? ~cin : cin;
            acc_r   <= '0;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= co_s;
          if (idx_r == LAST_IDX) begin
            sum_r   <= acc_next_s;
            cout_r  <= co_s;
            ovf_r   <= co_s ^ cm_s;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + IDXW'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          idx_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

  seq_addsub_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_r),
    .done  (done_r),
    .state (state_r)
  );

endmodule

// File: tb/tb_seq_addsub.sv
// Directed self-checking bench for seq_addsub (16/4 and 8/8 configurations).
module tb_seq_addsub;

  logic        clk;
  logic        rst_n;

  logic        start, cin, sub;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  int checks   = 0;
  int failures = 0;
  int lat;
  int bn;
  int done_cnt;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; counts edges to done.
  task automatic wait_done(input string tag, output int l, output int bcnt);
    l = 0;
    bcnt = 0;
    while (!done && l < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      l++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic tsub, input logic [15:0] es,
                        input logic ec, input logic eo);
    int l;
    int bc;
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    wait_done(tag, l, bc);
    chk({tag, "_latency"}, 32'(l), 32'd4);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;

    // Reset state, sampled before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add / sub vectors.
    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_cin",   16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    run_op("sub_bin",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Start held high through RUN and DONE: mid-RUN start ignored, then
    // back-to-back second op with no IDLE bubble.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001;
    chk("b2b_busy_first", 32'(busy), 32'd1);
    wait_done("b2b1", lat, bn);
    chk("b2b1_latency", 32'(lat), 32'd4);
    chk("b2b1_sum", 32'(sum), 32'h5555);
    chk("b2b1_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_bubble_busy", 32'(busy), 32'd1);
    chk("b2b_no_bubble_done", 32'(done), 32'd0);
    chk("b2b_sum_held_in_run", 32'(sum), 32'h5555);
    wait_done("b2b2", lat, bn);
    chk("b2b2_latency", 32'(lat), 32'd4);
    chk("b2b2_sum", 32'(sum), 32'h8000);
    chk("b2b2_cout", 32'(cout), 32'd0);
    chk("b2b2_ovf", 32'(ovf), 32'd1);
    @(negedge clk);

    // Reset asserted in RUN cycle 2: immediate clear, no done afterwards.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd1 - 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    chk("midrst_sum_stays0", 32'(sum), 32'd0);

    // Start accepted on the very first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'h0F0F; b = 16'hF0F1; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("postrst_busy", 32'(busy), 32'd1);
    wait_done("postrst", lat, bn);
    chk("postrst_latency", 32'(lat), 32'd4);
    chk("postrst_sum", 32'(sum), 32'h0001);
    chk("postrst_cout", 32'(cout), 32'd1);
    chk("postrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    // Single-chunk configuration: 8-bit, one RUN cycle.
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    chk("w8_busy", 32'(busy8), 32'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w8_done_seen", 32'(done8), 32'd1);
    chk("w8_latency", 32'(lat), 32'd1);
    chk("w8_sum", 32'(sum8), 32'h01);
    chk("w8_cout", 32'(cout8), 32'd1);
    chk("w8_ovf", 32'(ovf8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
